apb_alarm_seq: RTL
==================

Name: apb_alarm_seq

Overview:
- APB master sequencer that drives the apb_alarm peripheral on behalf of simple request/ack logic.
- Hides the peripheral's time-load handshake: it writes bit16 set, then clear, then set again, with idle gaps between the writes.
- Also performs alarm programming, alarm-off writes and TIME_NOW readback.
- Sits between a control FSM or button logic and the apb_alarm slave port.

Parameters:
GAP_CYCLES, 5, idle cycles between the three TIME_INIT writes (min 1)
POLL_DIV, 1000, cycles between automatic TIME_NOW reads (only with ALARM_SEQ_POLL_EN)
TIMEOUT, 64, max ACCESS cycles waiting for pready_i before abort

Ports:
pclk_i  in  1  clock
presetn_i  in  1  async active-low reset
time_req_i  in  1  pulse: load time_val_i into peripheral
time_val_i  in  16  BCD hhmm, sampled when time_req_i=1
alarm_req_i  in  1  pulse: program alarm
alarm_val_i  in  16  BCD hhmm, sampled with alarm_req_i
alarm_en_i  in  1  alarm enable (bit16 of ALARM write), sampled with alarm_req_i
off_req_i  in  1  pulse: write 32'h1 to ALARM_OFF
poll_req_i  in  1  pulse: read TIME_NOW
err_clr_i  in  1  clears err_o
busy_o  out  1  operation in progress
done_o  out  1  1-cycle pulse at end of each operation
err_o  out  1  sticky: pslverr or timeout seen
time_now_o  out  32  last TIME_NOW read data
time_now_vld_o  out  1  1-cycle pulse when time_now_o updates
paddr_o  out  32  APB address
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB write
pwdata_o  out  32  APB write data
pstrb_o  out  4  always 4'b1111
pready_i  in  1  APB ready
prdata_i  in  32  APB read data
pslverr_i  in  1  APB error

Behaviour:
- Interface: one clock, pclk_i. Reset presetn_i is asynchronous and active-low.
- Reset values:
  - All outputs 0, except pstrb_o, which is 4'b1111.
  - Pending flags cleared; FSM in IDLE.
- Pending flags:
  - Each *_req_i pulse sets its pending flag and captures its value into a shadow register.
  - A new request for an op already pending overwrites the shadow register (latest wins).
  - Shadow registers of an op in progress are frozen until that op completes.
- Grant priority in IDLE: OFF > TIME > ALARM > POLL. The grant clears the flag.
- Operations (addr, data):
  - TIME: three writes to 0x0 with data {15'b0,1,val}, {15'b0,0,val}, {15'b0,1,val}. GAP_CYCLES idle cycles between writes.
  - ALARM: one write to 0x4 with data {15'b0,en,val}.
  - OFF: one write to 0xC with data 32'h1.
  - POLL: one read from 0x8. On completion, time_now_o<=prdata_i and time_now_vld_o pulses.
- FSM states: IDLE -> SETUP -> ACCESS -> (GAP -> SETUP | IDLE).
  - SETUP: one cycle, psel=1, penable=0.
  - ACCESS: psel=1, penable=1, held until pready_i=1.
  - GAP: psel=0, counts GAP_CYCLES.
  - addr, data and write stay stable through SETUP+ACCESS.
  - psel_o/penable_o drop the cycle after pready_i is sampled high.
- busy_o: 1 from the grant cycle until the done_o cycle inclusive.
- done_o: pulses on the cycle the FSM returns to IDLE.
- Next grant: earliest on the cycle after done_o, so back-to-back ops have at least one idle cycle.
- Error handling:
  - pslverr_i=1 with pready_i=1 sets err_o.
  - Access timeout (TIMEOUT cycles in ACCESS without pready_i) deasserts psel/penable and sets err_o.
  - Either error aborts the remaining writes of a TIME op; done_o still pulses.
  - A POLL that errors leaves time_now_o unchanged and does not pulse time_now_vld_o.
- err_clr_i clears err_o. If err_clr_i and an error occur in the same cycle, the error wins.
- Latency (pready_i tied 1), measured from the request cycle to done_o:
  - OFF, ALARM, POLL: 4 cycles (request capture, grant, SETUP, ACCESS).
  - TIME: 3+3*2+2*GAP_CYCLES cycles.
- A request arriving in the same cycle as its own grant is captured as a new pending request.
- Reset mid-transaction: bus outputs drop immediately (async); no partial sequence resumes after reset.

Optional Feature:
ALARM_SEQ_POLL_EN
- Defined:
  - Free-running counter raises the POLL pending flag every POLL_DIV cycles.
  - The counter restarts on reset only.
  - Auto-poll flag shares the poll_req_i flag; duplicates merge.
- Undefined:
  - Counter absent; POLL happens only on poll_req_i.
  - POLL_DIV is ignored.

Test Plan:
- Reset then time_req_i with time_val_i=16'h1052, pready_i=1:
  - writes 0x0: 32'h11052, 32'h01052, 32'h11052.
  - GAP_CYCLES=5 idle cycles between writes.
  - done_o after 19 cycles; err_o=0.
- alarm_req_i val=16'h1100 en=1 -> single write 0x4 data 32'h11100; busy_o high 4 cycles.
- poll_req_i, slave returns prdata_i=32'h00011053 after 3 wait states:
  - time_now_o=32'h00011053.
  - time_now_vld_o pulses once.
  - psel/penable held through the waits.
- off_req_i, time_req_i and alarm_req_i in the same cycle:
  - bus order OFF (0xC, 32'h1), then TIME (3 writes), then ALARM.
  - three done_o pulses.
- pslverr_i=1 on the 2nd TIME write:
  - err_o=1; 3rd write not issued; done_o pulses.
  - after err_clr_i, err_o=0.
- pready_i stuck 0 -> abort after 64 ACCESS cycles, err_o=1, FSM back to IDLE.
- With ALARM_SEQ_POLL_EN and POLL_DIV=100: reads of 0x8 every 100 cycles with no poll_req_i.

Source files
------------

// File: rtl/apb_alarm_seq.sv
// apb_alarm_seq: APB master sequencing TIME load (set/clear/set), ALARM, OFF and TIME_NOW poll on the apb_alarm slave.
// Latency: 4 cycles request->done_o for single accesses, 3+6+2*GAP_CYCLES for TIME; each ACCESS stalls on pready_i up to TIMEOUT.
// Optional: define ALARM_SEQ_POLL_EN for a free-running auto-poll every POLL_DIV cycles.
module apb_alarm_seq #(
    parameter int GAP_CYCLES = 5,
    parameter int POLL_DIV   = 1000,
    parameter int TIMEOUT    = 64
) (
    input  logic        pclk_i,
    input  logic        presetn_i,
    input  logic        time_req_i,
    input  logic [15:0] time_val_i,
    input  logic        alarm_req_i,
    input  logic [15:0] alarm_val_i,
    input  logic        alarm_en_i,
    input  logic        off_req_i,
    input  logic        poll_req_i,
    input  logic        err_clr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] time_now_o,
    output logic        time_now_vld_o,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    input  logic        pready_i,
    input  logic [31:0] prdata_i,
    input  logic        pslverr_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_GAP} state_t;
    typedef enum logic [1:0] {OP_OFF, OP_TIME, OP_ALARM, OP_POLL} op_t;

    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    if (GAP_CYCLES < 1 || TIMEOUT < 1 || POLL_DIV < 1) begin : g_bad_param
        $error("apb_alarm_seq: GAP_CYCLES, TIMEOUT and POLL_DIV must be >= 1");
    end

    state_t        r_state;
    state_t        w_state_nxt;
    op_t           r_op;
    op_t           w_grant_op;
    logic [1:0]    r_step;
    logic [GW-1:0] r_gap_cnt;
    logic [TW-1:0] r_to_cnt;

    logic          r_pend_off;
    logic          r_pend_time;
    logic          r_pend_alarm;
    logic          r_pend_poll;
    logic [15:0]   r_time_sh;
    logic [15:0]   r_alarm_sh;
    logic          r_alarm_en_sh;
    logic [15:0]   r_val;
    logic          r_en;

    logic          r_done;
    logic          r_err;
    logic          r_time_vld;
    logic [31:0]   r_time_now;

    logic          w_grant;
    logic          w_acc_ok;
    logic          w_slverr;
    logic          w_timeout;
    logic          w_abort;
    logic          w_auto_poll;
    logic          w_psel;
    logic          w_penable;
    logic          w_write;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;

    `ifdef ALARM_SEQ_POLL_EN
    localparam int PW = $clog2(POLL_DIV) + 1;
    logic [PW-1:0] r_poll_cnt;

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            r_poll_cnt <= '0;
        end else if (r_poll_cnt == PW'(POLL_DIV - 1)) begin
            r_poll_cnt <= '0;
        end else begin
            r_poll_cnt <= r_poll_cnt + PW'(1);
        end
    end

    assign w_auto_poll = (r_poll_cnt == PW'(POLL_DIV - 1));
    `else
    assign w_auto_poll = 1'b0;
    `endif

    always_comb begin
        w_grant_op = OP_POLL;
        if (r_pend_off) begin
            w_grant_op = OP_OFF;
        end else if (r_pend_time) begin
            w_grant_op = OP_TIME;
        end else if (r_pend_alarm) begin
            w_grant_op = OP_ALARM;
        end
    end

    // No grant in the done_o cycle: guarantees an idle cycle between operations.
    assign w_grant   = (r_state == ST_IDLE) && !r_done &&
                       (r_pend_off || r_pend_time || r_pend_alarm || r_pend_poll);
    assign w_acc_ok  = (r_state == ST_ACCESS) && pready_i;
    assign w_slverr  = w_acc_ok && pslverr_i;
    assign w_timeout = (r_state == ST_ACCESS) && !pready_i && (r_to_cnt == TO_LAST);
    assign w_abort   = w_slverr || w_timeout;

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_acc_ok) begin
                    w_state_nxt = (r_op == OP_TIME) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP:    if (r_gap_cnt == '0) w_state_nxt = (r_step == 2'd3) ? ST_IDLE : ST_SETUP;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_psel    = 1'b0;
        w_penable = 1'b0;
        w_write   = 1'b0;
        w_addr    = '0;
        w_wdata   = '0;
        if (r_state == ST_SETUP || r_state == ST_ACCESS) begin
            w_psel    = 1'b1;
            w_penable = (r_state == ST_ACCESS);
            case (r_op)
                OP_OFF: begin
                    w_addr  = 32'h0000_000C;
                    w_write = 1'b1;
                    w_wdata = 32'h0000_0001;
                end
                OP_TIME: begin
                    // Load handshake: bit16 set, clear, set on steps 0,1,2.
                    w_addr  = 32'h0000_0000;
                    w_write = 1'b1;
                    w_wdata = {15'b0, (r_step != 2'd1), r_val};
                end
                OP_ALARM: begin
                    w_addr  = 32'h0000_0004;
                    w_write = 1'b1;
                    w_wdata = {15'b0, r_en, r_val};
                end
                default: begin
                    w_addr  = 32'h0000_0008;
                end
            endcase
        end
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            r_op       <= OP_OFF;
            r_step     <= 2'd0;
            r_val      <= '0;
            r_en       <= 1'b0;
            r_gap_cnt  <= '0;
            r_to_cnt   <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_time_vld <= 1'b0;
            r_time_now <= '0;
        end else begin
            r_done     <= (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
            r_time_vld <= 1'b0;

            if (w_grant) begin
                r_op   <= w_grant_op;
                r_step <= 2'd0;
                r_val  <= (w_grant_op == OP_TIME) ? r_time_sh : r_alarm_sh;
                r_en   <= r_alarm_en_sh;
            end

            if (r_state == ST_SETUP) begin
                r_to_cnt <= '0;
            end else if (r_state == ST_ACCESS) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end

            // After the third TIME write a single trailing idle cycle precedes done_o.
            if (w_acc_ok && !pslverr_i && r_op == OP_TIME) begin
                r_step    <= r_step + 2'd1;
                r_gap_cnt <= (r_step == 2'd2) ? '0 : GAP_LAST;
            end else if (r_state == ST_GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - GW'(1);
            end

            if (w_acc_ok && !pslverr_i && r_op == OP_POLL) begin
                r_time_now <= prdata_i;
                r_time_vld <= 1'b1;
            end

            if (w_abort) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
        end
    end

    // A request in its own grant cycle re-arms the flag (set beats clear).
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            r_pend_off    <= 1'b0;
            r_pend_time   <= 1'b0;
            r_pend_alarm  <= 1'b0;
            r_pend_poll   <= 1'b0;
            r_time_sh     <= '0;
            r_alarm_sh    <= '0;
            r_alarm_en_sh <= 1'b0;
        end else begin
            r_pend_off   <= off_req_i   || (r_pend_off   && !(w_grant && w_grant_op == OP_OFF));
            r_pend_time  <= time_req_i  || (r_pend_time  && !(w_grant && w_grant_op == OP_TIME));
            r_pend_alarm <= alarm_req_i || (r_pend_alarm && !(w_grant && w_grant_op == OP_ALARM));
            r_pend_poll  <= poll_req_i  || w_auto_poll ||
                            (r_pend_poll && !(w_grant && w_grant_op == OP_POLL));
            if (time_req_i) begin
                r_time_sh <= time_val_i;
            end
            if (alarm_req_i) begin
                r_alarm_sh    <= alarm_val_i;
                r_alarm_en_sh <= alarm_en_i;
            end
        end
    end

    assign busy_o         = (r_state != ST_IDLE) || w_grant || r_done;
    assign done_o         = r_done;
    assign err_o          = r_err;
    assign time_now_o     = r_time_now;
    assign time_now_vld_o = r_time_vld;
    assign paddr_o        = w_addr;
    assign psel_o         = w_psel;
    assign penable_o      = w_penable;
    assign pwrite_o       = w_write;
    assign pwdata_o       = w_wdata;
    assign pstrb_o        = 4'b1111;

endmodule
